tdp_ram_be_param: RTL and testbench

- Parametrised single-clock true dual-port RAM; both ports read and write, with per-byte write enables.
- Successor to the fixed 6144x16 dual-port array used by the core memory subsystem.
- Adds: a writable port B, registered read data with valid strobes, a defined read-during-write mode, write-collision arbitration, and a post-reset hardware clear sequencer.
- Sits between the core load/store unit (port A) and the debug/DMA path (port B).

---
 rtl/tdp_ram_be_param.sv | 177 +++++++++++++++++
 tb/tb_tdp_ram_be_param.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdp_ram_be_param.sv
// Single-clock true dual-port RAM with byte enables, registered read data, write
// collision arbitration (port A wins per byte) and a post-reset clear sequencer.
// Optional macro TDP_RAM_OUTREG_EN adds a second output register stage (latency 2).
module tdp_ram_be_param #(
  parameter int              DEPTH    = 6144,
  parameter int              DW       = 16,
  parameter int              AW       = 13,
  parameter int              RDW_MODE = 0,
  parameter logic [DW-1:0]   CLR_VAL  = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               init_done,
  input  logic               a_en,
  input  logic [DW/8-1:0]    a_we,
  input  logic [AW-1:0]      a_addr,
  input  logic [DW-1:0]      a_din,
  output logic [DW-1:0]      a_dout,
  output logic               a_vld,
  input  logic               b_en,
  input  logic [DW/8-1:0]    b_we,
  input  logic [AW-1:0]      b_addr,
  input  logic [DW-1:0]      b_din,
  output logic [DW-1:0]      b_dout,
  output logic               b_vld,
  output logic               collide,
  output logic               oor_err
);

  localparam int            BW       = DW / 8;
  localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_clr_we;

  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_run, w_same;
  logic            w_a_acc, w_a_oor, w_a_wr;
  logic            w_b_acc, w_b_oor, w_b_wr;
  logic [IW-1:0]   w_a_idx, w_b_idx;
  logic [DW-1:0]   w_a_old, w_b_old, w_a_fin, w_b_fin, w_a_rd, w_b_rd;

  logic [DW-1:0]   r_a_dout, r_b_dout;
  logic            r_a_vld, r_b_vld, r_collide, r_oor;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LP_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign init_done = (r_state == S_RUN);

  assign w_run   = (r_state == S_RUN) && reset_n;
  assign w_same  = (a_addr == b_addr);
  assign w_a_acc = w_run && a_en;
  assign w_b_acc = w_run && b_en;
  assign w_a_oor = ({1'b0, a_addr} >= LP_DEPTH);
  assign w_b_oor = ({1'b0, b_addr} >= LP_DEPTH);
  assign w_a_wr  = w_a_acc && (|a_we) && !w_a_oor;
  assign w_b_wr  = w_b_acc && (|b_we) && !w_b_oor;
  assign w_a_idx = a_addr[IW-1:0];
  assign w_b_idx = b_addr[IW-1:0];
  assign w_a_old = w_a_oor ? '0 : r_mem[w_a_idx];
  assign w_b_old = w_b_oor ? '0 : r_mem[w_b_idx];

  // Merged word each writer leaves behind; on a shared address both carry the same value.
  always_comb begin
    w_a_fin = w_a_old;
    w_b_fin = w_b_old;
    for (int k = 0; k < BW; k++) begin
      if (w_a_wr && a_we[k])
        w_a_fin[8*k +: 8] = a_din[8*k +: 8];
      else if (w_b_wr && w_same && b_we[k])
        w_a_fin[8*k +: 8] = b_din[8*k +: 8];
      if (w_a_wr && w_same && a_we[k])
        w_b_fin[8*k +: 8] = a_din[8*k +: 8];
      else if (w_b_wr && b_we[k])
        w_b_fin[8*k +: 8] = b_din[8*k +: 8];
    end
  end

  assign w_a_rd = (RDW_MODE == 1 && w_a_wr) ? w_a_fin : w_a_old;
  assign w_b_rd = (RDW_MODE == 1 && w_b_wr) ? w_b_fin : w_b_old;

  always_ff @(posedge clk) begin
    if (w_clr_we)
      r_mem[r_cnt[IW-1:0]] <= CLR_VAL;
    if (w_b_wr)
      r_mem[w_b_idx] <= w_b_fin;
    if (w_a_wr)
      r_mem[w_a_idx] <= w_a_fin;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a_dout  <= '0;
      r_b_dout  <= '0;
      r_a_vld   <= 1'b0;
      r_b_vld   <= 1'b0;
      r_collide <= 1'b0;
      r_oor     <= 1'b0;
    end else begin
      r_a_vld   <= w_a_acc;
      r_b_vld   <= w_b_acc;
      if (w_a_acc) r_a_dout <= w_a_rd;
      if (w_b_acc) r_b_dout <= w_b_rd;
      r_collide <= w_a_wr && w_b_wr && w_same;
      r_oor     <= (w_a_acc && w_a_oor) || (w_b_acc && w_b_oor);
    end
  end

`ifdef TDP_RAM_OUTREG_EN
  logic [DW-1:0] r_a_dout_q, r_b_dout_q;
  logic          r_a_vld_q, r_b_vld_q, r_collide_q, r_oor_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a_dout_q  <= '0;
      r_b_dout_q  <= '0;
      r_a_vld_q   <= 1'b0;
      r_b_vld_q   <= 1'b0;
      r_collide_q <= 1'b0;
      r_oor_q     <= 1'b0;
    end else begin
      r_a_dout_q  <= r_a_dout;
      r_b_dout_q  <= r_b_dout;
      r_a_vld_q   <= r_a_vld;
      r_b_vld_q   <= r_b_vld;
      r_collide_q <= r_collide;
      r_oor_q     <= r_oor;
    end
  end

  assign a_dout  = r_a_dout_q;
  assign b_dout  = r_b_dout_q;
  assign a_vld   = r_a_vld_q;
  assign b_vld   = r_b_vld_q;
  assign collide = r_collide_q;
  assign oor_err = r_oor_q;
`else
  assign a_dout  = r_a_dout;
  assign b_dout  = r_b_dout;
  assign a_vld   = r_a_vld;
  assign b_vld   = r_b_vld;
  assign collide = r_collide;
  assign oor_err = r_oor;
`endif

endmodule

// File: tb/tb_tdp_ram_be_param.sv
// Bench for tdp_ram_be_param: two instances (read-first and write-first) driven in
// lockstep, checked against a reference memory through per-port expectation queues.
module tb_tdp_ram_be_param;

  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int AW    = 5;
`ifdef TDP_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_en, b_en;
  logic [1:0]    a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;

  logic          init_done0, init_done1;
  logic [DW-1:0] a_dout0, a_dout1, b_dout0, b_dout1;
  logic          a_vld0, a_vld1, b_vld0, b_vld1;
  logic          collide0, collide1, oor0, oor1;

  typedef struct { int due; logic [DW-1:0] d0; logic [DW-1:0] d1; } rd_t;
  typedef struct { int due; logic col; logic oor; } fl_t;

  rd_t           qa[$], qb[$];
  fl_t           qf[$];
  logic [DW-1:0] m [32];
  int            n_pass = 0;
  int            n_total = 0;
  int            cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdp_ram_be_param #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .RDW_MODE(0), .CLR_VAL(16'h0000)) dut0 (
    .clk(clk), .reset_n(reset_n), .init_done(init_done0),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout0), .a_vld(a_vld0),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout0), .b_vld(b_vld0),
    .collide(collide0), .oor_err(oor0));

  tdp_ram_be_param #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .RDW_MODE(1), .CLR_VAL(16'h0000)) dut1 (
    .clk(clk), .reset_n(reset_n), .init_done(init_done1),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout1), .a_vld(a_vld1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout1), .b_vld(b_vld1),
    .collide(collide1), .oor_err(oor1));

  // Scoreboard side: every cycle, vld/flags must match what is due now; data when valid.
  always @(negedge clk) begin : mon
    rd_t  e;
    fl_t  f;
    logic ev;
    while (qa.size() > 0 && qa[0].due < cyc) begin
      n_total++;
      $display("FAIL a_stale cyc=%0d due=%0d", cyc, qa[0].due);
      void'(qa.pop_front());
    end
    ev = (qa.size() > 0 && qa[0].due == cyc);
    n_total++;
    if (a_vld0 !== ev || a_vld1 !== ev)
      $display("FAIL a_vld cyc=%0d got %b/%b exp %b", cyc, a_vld0, a_vld1, ev);
    else n_pass++;
    if (ev) begin
      e = qa.pop_front();
      n_total++;
      if (a_dout0 !== e.d0 || a_dout1 !== e.d1)
        $display("FAIL a_dout cyc=%0d got %h/%h exp %h/%h", cyc, a_dout0, a_dout1, e.d0, e.d1);
      else n_pass++;
    end

    while (qb.size() > 0 && qb[0].due < cyc) begin
      n_total++;
      $display("FAIL b_stale cyc=%0d due=%0d", cyc, qb[0].due);
      void'(qb.pop_front());
    end
    ev = (qb.size() > 0 && qb[0].due == cyc);
    n_total++;
    if (b_vld0 !== ev || b_vld1 !== ev)
      $display("FAIL b_vld cyc=%0d got %b/%b exp %b", cyc, b_vld0, b_vld1, ev);
    else n_pass++;
    if (ev) begin
      e = qb.pop_front();
      n_total++;
      if (b_dout0 !== e.d0 || b_dout1 !== e.d1)
        $display("FAIL b_dout cyc=%0d got %h/%h exp %h/%h", cyc, b_dout0, b_dout1, e.d0, e.d1);
      else n_pass++;
    end

    while (qf.size() > 0 && qf[0].due < cyc) void'(qf.pop_front());
    f = '{due: cyc, col: 1'b0, oor: 1'b0};
    if (qf.size() > 0 && qf[0].due == cyc) f = qf.pop_front();
    n_total++;
    if (collide0 !== f.col || collide1 !== f.col || oor0 !== f.oor || oor1 !== f.oor)
      $display("FAIL flags cyc=%0d collide %b/%b oor %b/%b exp collide %b oor %b",
               cyc, collide0, collide1, oor0, oor1, f.col, f.oor);
    else n_pass++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
  endtask

  // Drives one RUN-state cycle and records what both instances must return.
  task automatic drive(input logic ae, input logic [1:0] awe, input logic [AW-1:0] aad,
                       input logic [DW-1:0] adi, input logic be, input logic [1:0] bwe,
                       input logic [AW-1:0] bad, input logic [DW-1:0] bdi);
    logic          ao, bo, aw, bw;
    logic [DW-1:0] aold, bold;
    a_en = ae; a_we = awe; a_addr = aad; a_din = adi;
    b_en = be; b_we = bwe; b_addr = bad; b_din = bdi;
    ao   = (aad >= DEPTH);
    bo   = (bad >= DEPTH);
    aw   = ae && (awe != 0) && !ao;
    bw   = be && (bwe != 0) && !bo;
    aold = ao ? '0 : m[aad];
    bold = bo ? '0 : m[bad];
    for (int k = 0; k < 2; k++) if (bw && bwe[k]) m[bad][8*k +: 8] = bdi[8*k +: 8];
    for (int k = 0; k < 2; k++) if (aw && awe[k]) m[aad][8*k +: 8] = adi[8*k +: 8];
    if (ae) qa.push_back('{due: cyc + LAT, d0: aold, d1: aw ? m[aad] : aold});
    if (be) qb.push_back('{due: cyc + LAT, d0: bold, d1: bw ? m[bad] : bold});
    if ((aw && bw && aad == bad) || (ae && ao) || (be && bo))
      qf.push_back('{due: cyc + LAT, col: aw && bw && aad == bad, oor: (ae && ao) || (be && bo)});
    step();
    idle();
  endtask

  task automatic drain();
    int t = 0;
    while ((qa.size() + qb.size() + qf.size()) > 0 && t < 10) begin
      step();
      t++;
    end
    n_total++;
    if ((qa.size() + qb.size() + qf.size()) > 0) begin
      $display("FAIL drain pending=%0d exp 0", qa.size() + qb.size() + qf.size());
      qa.delete(); qb.delete(); qf.delete();
    end else n_pass++;
  endtask

  // Counts cycles from reset release until init_done, issuing requests that must be ignored.
  task automatic count_clear(output int n);
    n = 0;
    reset_n = 1'b1;
    a_en = 1'b1; a_we = 2'b11; a_addr = 5'd2; a_din = 16'hFFFF;
    b_en = 1'b1; b_we = 2'b11; b_addr = 5'd2; b_din = 16'h1111;
    while (!init_done0 && n < 40) begin
      if (n == 4) begin a_addr = 5'd20; b_we = 2'b00; b_addr = 5'd25; end
      if (n == 10) idle();
      step();
      n++;
    end
    idle();
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 2'b00, AW'(i), '0, 1'b1, 2'b00, AW'(DEPTH - 1 - i), '0);
    drain();
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    idle();
    step();
    step();
    n_total++;
    if (init_done0 !== 1'b0 || a_dout0 !== '0 || b_dout0 !== '0 || a_vld0 !== 1'b0 ||
        b_vld0 !== 1'b0 || collide0 !== 1'b0 || oor0 !== 1'b0)
      $display("FAIL reset_dut0 init=%b ad=%h bd=%h av=%b bv=%b col=%b oor=%b exp all 0",
               init_done0, a_dout0, b_dout0, a_vld0, b_vld0, collide0, oor0);
    else n_pass++;
    n_total++;
    if (init_done1 !== 1'b0 || a_dout1 !== '0 || b_dout1 !== '0 || a_vld1 !== 1'b0 ||
        b_vld1 !== 1'b0 || collide1 !== 1'b0 || oor1 !== 1'b0)
      $display("FAIL reset_dut1 init=%b ad=%h bd=%h av=%b bv=%b col=%b oor=%b exp all 0",
               init_done1, a_dout1, b_dout1, a_vld1, b_vld1, collide1, oor1);
    else n_pass++;
    for (int i = 0; i < 32; i++) m[i] = '0;
    count_clear(n);
    n_total++;
    if (n != DEPTH || init_done1 !== 1'b1)
      $display("FAIL clear_len got %0d cycles (dut1 init=%b) exp %0d", n, init_done1, DEPTH);
    else n_pass++;
    read_all();
  endtask

  task automatic test_cross_port();
    drive(1'b1, 2'b11, 5'd3, 16'hBEEF, 1'b0, 2'b00, '0, '0);
    drive(1'b0, 2'b00, '0, '0, 1'b0, 2'b00, '0, '0);
    drive(1'b0, 2'b00, '0, '0, 1'b1, 2'b00, 5'd3, '0);
    drain();
    n_total++;
    if (m[3] !== 16'hBEEF) $display("FAIL model_beef got %h exp beef", m[3]);
    else n_pass++;
  endtask

  task automatic test_byte_rdw();
    drive(1'b1, 2'b11, 5'd7, 16'h1234, 1'b0, 2'b00, '0, '0);
    drive(1'b1, 2'b01, 5'd7, 16'h00AB, 1'b0, 2'b00, '0, '0);
    drive(1'b1, 2'b00, 5'd7, '0, 1'b0, 2'b00, '0, '0);
    drive(1'b1, 2'b00, 5'd7, '0, 1'b1, 2'b10, 5'd7, 16'h5600);
    drive(1'b0, 2'b00, '0, '0, 1'b1, 2'b00, 5'd7, '0);
    drain();
  endtask

  task automatic test_collision();
    drive(1'b1, 2'b01, 5'd5, 16'hAAAA, 1'b1, 2'b11, 5'd5, 16'h5555);
    drive(1'b1, 2'b00, 5'd5, '0, 1'b1, 2'b00, 5'd5, '0);
    drive(1'b1, 2'b10, 5'd6, 16'hC300, 1'b1, 2'b01, 5'd6, 16'h003C);
    drive(1'b1, 2'b11, 5'd8, 16'h1111, 1'b1, 2'b11, 5'd9, 16'h2222);
    drive(1'b1, 2'b00, 5'd6, '0, 1'b1, 2'b00, 5'd8, '0);
    drain();
    n_total++;
    if (m[5] !== 16'h55AA) $display("FAIL model_collide got %h exp 55aa", m[5]);
    else n_pass++;
  endtask

  task automatic test_oor();
    drive(1'b1, 2'b11, 5'd16, 16'hFFFF, 1'b0, 2'b00, '0, '0);
    drive(1'b1, 2'b00, 5'd16, '0, 1'b0, 2'b00, '0, '0);
    drive(1'b0, 2'b00, '0, '0, 1'b1, 2'b11, 5'd20, 16'h7777);
    drive(1'b1, 2'b00, 5'd0, '0, 1'b1, 2'b00, 5'd4, '0);
    drive(1'b1, 2'b00, 5'd31, '0, 1'b1, 2'b11, 5'd31, 16'h9999);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] aad, bad;
    for (int i = 0; i < 300; i++) begin
      aad = AW'($urandom_range(0, 19));
      bad = ($urandom_range(0, 2) == 0) ? aad : AW'($urandom_range(0, 19));
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), aad, 16'($urandom),
            $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), bad, 16'($urandom));
    end
    drain();
  endtask

  task automatic test_reclear();
    int n;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (5) step();
    reset_n = 1'b0;
    step();
    n_total++;
    if (init_done0 !== 1'b0 || init_done1 !== 1'b0)
      $display("FAIL reclear_init got %b/%b exp 0", init_done0, init_done1);
    else n_pass++;
    for (int i = 0; i < 32; i++) m[i] = '0;
    count_clear(n);
    n_total++;
    if (n != DEPTH) $display("FAIL reclear_len got %0d cycles exp %0d", n, DEPTH);
    else n_pass++;
    read_all();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    test_reset();
    test_cross_port();
    test_byte_rdw();
    test_collision();
    test_oor();
    test_back_to_back();
    test_reclear();
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
